jtdd_gfx_arb: RTL and testbench
===============================

// Module: jtdd_gfx_arb
// PURPOSE
// Shares one graphics-ROM SDRAM read port among the char, scroll and object layer fetchers.
// Each layer sees a private ROM port: it holds addr+cs and waits for ok.
// Keeps a one-entry tag/data cache per layer and serves misses round-robin.
// Sits between jtdd_char/jtdd_scroll/jtdd_obj and the SDRAM controller.
// PARAMETERS
// CHAR_AW     15          char ROM word-address width
// SCR_AW      17          scroll ROM word-address width
// OBJ_AW      18          object ROM word-address width
// SDRAM_AW    22          SDRAM word-address width
// CHAR_OFFSET 22'h00000   SDRAM base of char ROM
// SCR_OFFSET  22'h10000   SDRAM base of scroll ROM
// OBJ_OFFSET  22'h30000   SDRAM base of object ROM
// TIMEOUT     255         max cycles waiting for sdram_rdy (8-bit counter)
// PORTS
// clk         in   1        system clock
// rst_n       in   1        asynchronous, active-low reset
// downloading in   1        ROM download active: flush caches, issue nothing
// char_cs     in   1        char layer request
// char_addr   in   CHAR_AW  char word address
// char_data   out  16       char data
// char_ok     out  1        char data valid for current char_addr
// scr_cs/scr_addr[SCR_AW]/scr_data[16]/scr_ok    same as char, scroll layer
// obj_cs/obj_addr[OBJ_AW]/obj_data[16]/obj_ok    same as char, object layer
// sdram_addr  out  SDRAM_AW read address = OFFSET_i + zero-extended addr_i
// sdram_req   out  1        read request, held until sdram_ack
// sdram_ack   in   1        controller accepted request
// sdram_rdy   in   1        sdram_data valid this cycle (one-cycle pulse)
// sdram_data  in   16       read data
// timeout_cnt out  8        saturating count of timed-out fetches
// BEHAVIOUR
// - Reset: all outputs 0, tags 0, valid 0, state IDLE, rr pointer = char, timeout_cnt 0.
// - Per layer i: hit_i = valid_i && tag_i==addr_i; ok_i = cs_i && hit_i (combinational);
//   data_i is the registered cached word. pend_i = cs_i && !hit_i && !downloading.
// - FSM IDLE: if any pend_i, pick first pending after last grant (order char->scr->obj->char);
//   register grant, sdram_addr, sdram_req<=1, tag_i<=addr_i, valid_i<=0 -> WAIT_ACK.
//   Miss to sdram_req high: 1 cycle.
// - WAIT_ACK: on sdram_ack, sdram_req<=0 -> WAIT_DATA; if sdram_rdy in same cycle,
//   complete as WAIT_DATA does -> IDLE.
// - WAIT_DATA: on sdram_rdy, data_g<=sdram_data, valid_g<=1 -> IDLE; ok_g rises next cycle
//   if addr_g still equals tag_g.
// - Watchdog: 8-bit counter cleared on entry to WAIT_ACK; counts in WAIT_ACK/WAIT_DATA;
//   on reaching TIMEOUT: drop sdram_req, leave valid_g 0, timeout_cnt+=1 (saturate at 255), -> IDLE.
// - Addr change mid-fetch: fetch completes into the old tag; ok stays low; refetch later.
// - cs deasserted mid-fetch: fetch still completes and is cached.
// - downloading=1: valid_* cleared every cycle; no new request; in-flight fetch finishes
//   but its data is not marked valid.
// - Simultaneous rdy and new pend on same layer: completion wins; pend re-evaluated in IDLE.
// - Fairness: any pending layer is granted within 2 other fetches.
// - rst_n low mid-fetch: immediate return to reset state; sdram_req drops asynchronously.
// TESTING
// - scr_cs=1, scr_addr=17'h1234, ack +2, rdy +3 with 16'hBEEF -> sdram_addr=22'h11234,
//   scr_data=16'hBEEF, scr_ok=1.
// - Repeat same scr_addr after hit -> scr_ok=1 same cycle, no sdram_req.
// - All three cs together on misses -> grants char, scr, obj in turn; then scr+obj again ->
//   grants scr before obj (rr continues from last grant).
// - Change obj_addr between ack and rdy -> obj_ok stays 0; second fetch for new address issued.
// - No rdy for 255 cycles -> sdram_req=0, timeout_cnt=1, layer ok=0, next pend served.
// - downloading pulse after three hits -> all ok drop; no sdram_req while high; refetch after.

Source files
------------

// File: rtl/jtdd_gfx_arb.sv
// jtdd_gfx_arb
// Shares one graphics-ROM SDRAM read port among the char, scroll and object
// layer fetchers. Each layer holds addr+cs on a private ROM-style port and
// waits for ok. A one-entry tag/data cache per layer answers repeat reads
// without touching SDRAM; misses are served one at a time, round-robin.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   downloading           ROM download in progress: caches flushed, no reads
//   char_cs/addr/data/ok  char layer port   (CHAR_AW-bit word address)
//   scr_cs/addr/data/ok   scroll layer port (SCR_AW-bit word address)
//   obj_cs/addr/data/ok   object layer port (OBJ_AW-bit word address)
//   sdram_addr/req        read request to the SDRAM controller, req held to ack
//   sdram_ack             controller accepted the request
//   sdram_rdy/data        read data strobe (one-cycle pulse) and word
//   timeout_cnt           saturating count of fetches dropped by the watchdog
module jtdd_gfx_arb #(
  parameter int                  CHAR_AW     = 15,
  parameter int                  SCR_AW      = 17,
  parameter int                  OBJ_AW      = 18,
  parameter int                  SDRAM_AW    = 22,
  parameter logic [SDRAM_AW-1:0] CHAR_OFFSET = 22'h00000,
  parameter logic [SDRAM_AW-1:0] SCR_OFFSET  = 22'h10000,
  parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h30000,
  parameter int                  TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic                char_cs,
  input  logic [CHAR_AW-1:0]  char_addr,
  output logic [15:0]         char_data,
  output logic                char_ok,
  input  logic                scr_cs,
  input  logic [SCR_AW-1:0]   scr_addr,
  output logic [15:0]         scr_data,
  output logic                scr_ok,
  input  logic                obj_cs,
  input  logic [OBJ_AW-1:0]   obj_addr,
  output logic [15:0]         obj_data,
  output logic                obj_ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [15:0]         sdram_data,
  output logic [7:0]          timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  // Watchdog fires on the cycle the counter holds TIMEOUT-1, so sdram_req
  // stays high for exactly TIMEOUT cycles when the controller never answers.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t              st, st_nx;
  logic [1:0]          rr;        // highest-priority layer for the next grant
  logic [1:0]          gnt;       // layer owning the fetch in flight
  logic [7:0]          wd;
  logic [2:0]          cs_v, hit, pend, vld;
  logic [SDRAM_AW-1:0] lay_addr [3];
  logic [SDRAM_AW-1:0] req_addr [3];
  logic [SDRAM_AW-1:0] tag      [3];
  logic [15:0]         data     [3];
  logic [1:0]          c1, c2, pick;
  logic                issue, done, tmo;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign cs_v        = {obj_cs, scr_cs, char_cs};
  assign lay_addr[0] = SDRAM_AW'(char_addr);
  assign lay_addr[1] = SDRAM_AW'(scr_addr);
  assign lay_addr[2] = SDRAM_AW'(obj_addr);
  assign req_addr[0] = CHAR_OFFSET + lay_addr[0];
  assign req_addr[1] = SCR_OFFSET  + lay_addr[1];
  assign req_addr[2] = OBJ_OFFSET  + lay_addr[2];

  always_comb begin
    hit = 3'b000;
    for (int i = 0; i < 3; i++) begin
      hit[i] = vld[i] && (tag[i] == lay_addr[i]);
    end
  end

  assign pend = cs_v & ~hit & {3{~downloading}};

  assign char_ok   = cs_v[0] & hit[0];
  assign scr_ok    = cs_v[1] & hit[1];
  assign obj_ok    = cs_v[2] & hit[2];
  assign char_data = data[0];
  assign scr_data  = data[1];
  assign obj_data  = data[2];

  // Scan rr, rr+1, rr+2 (cyclic); the nearest pending layer wins.
  always_comb begin
    c1   = nxt(rr);
    c2   = nxt(c1);
    pick = rr;
    if (pend[c2]) pick = c2;
    if (pend[c1]) pick = c1;
    if (pend[rr]) pick = rr;
  end

  always_comb begin
    st_nx = st;
    issue = 1'b0;
    done  = 1'b0;
    tmo   = 1'b0;
    case (st)
      IDLE: begin
        if (|pend) begin
          issue = 1'b1;
          st_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          // data may come back in the same cycle as the ack
          if (sdram_rdy) begin
            done  = 1'b1;
            st_nx = IDLE;
          end else begin
            st_nx = WAIT_DATA;
          end
        end else if (wd >= WD_LAST) begin
          tmo   = 1'b1;
          st_nx = IDLE;
        end
      end
      WAIT_DATA: begin
        if (sdram_rdy) begin
          done  = 1'b1;
          st_nx = IDLE;
        end else if (wd >= WD_LAST) begin
          tmo   = 1'b1;
          st_nx = IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      rr          <= 2'd0;
      gnt         <= 2'd0;
      wd          <= 8'd0;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      timeout_cnt <= 8'd0;
      vld         <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        tag[i]  <= '0;
        data[i] <= 16'd0;
      end
    end else begin
      st <= st_nx;
      if (issue) begin
        gnt        <= pick;
        rr         <= nxt(pick);
        sdram_addr <= req_addr[pick];
        sdram_req  <= 1'b1;
        tag[pick]  <= lay_addr[pick];
        vld[pick]  <= 1'b0;
        wd         <= 8'd0;
      end else if (st != IDLE) begin
        wd <= wd + 8'd1;
      end
      if (st == WAIT_ACK && sdram_ack) sdram_req <= 1'b0;
      if (tmo) begin
        sdram_req <= 1'b0;
        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
      end
      // The fetch always lands under the tag captured at grant time; a layer
      // that moved on meanwhile simply misses and is refetched later.
      if (done) begin
        data[gnt] <= sdram_data;
        vld[gnt]  <= ~downloading;
      end
      if (downloading) vld <= 3'b000;
    end
  end

endmodule

// File: tb/tb_jtdd_gfx_arb.sv
module tb_jtdd_gfx_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic        char_cs = 1'b0, scr_cs = 1'b0, obj_cs = 1'b0;
  logic [14:0] char_addr = '0;
  logic [16:0] scr_addr = '0;
  logic [17:0] obj_addr = '0;
  logic [15:0] char_data, scr_data, obj_data;
  logic        char_ok, scr_ok, obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0, sdram_rdy = 1'b0;
  logic [15:0] sdram_data = '0;
  logic [7:0]  timeout_cnt;

  int checks = 0;
  int failures = 0;

  // SDRAM responder controls
  bit          mute = 1'b0, rand_mode = 1'b0, force_en = 1'b0;
  logic [15:0] force_val = '0;
  int          ack_cfg = 0, rdy_cfg = 0;

  // scoreboard queues
  logic [21:0] exp_req [$];
  logic [15:0] exp_c [$];
  logic [15:0] exp_s [$];
  logic [15:0] exp_o [$];

  // reference model: per-layer cached address/data and next-priority layer
  logic [17:0] m_tag [3];
  bit          m_val [3];
  logic [15:0] m_dat [3];
  int          m_rr = 0;

  jtdd_gfx_arb dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_rdy(sdram_rdy), .sdram_data(sdram_data), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [21:0] a);
    return a[15:0] ^ {10'd0, a[21:16]} ^ 16'h5A3C;
  endfunction

  function automatic logic [21:0] full(input int l, input logic [17:0] a);
    case (l)
      0:       return 22'h00000 + {7'd0, a[14:0]};
      1:       return 22'h10000 + {5'd0, a[16:0]};
      default: return 22'h30000 + {4'd0, a};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push expected traffic for a set of layers requesting together: hits are
  // answered from the model cache, misses are fetched cyclically from m_rr.
  task automatic model_fetch(input logic [2:0] mask, input logic [17:0] a0,
                             input logic [17:0] a1, input logic [17:0] a2);
    logic [17:0] a [3];
    logic [21:0] fa;
    int last, l;
    a[0] = {3'd0, a0[14:0]};
    a[1] = {1'b0, a1[16:0]};
    a[2] = a2;
    last = -1;
    for (int k = 0; k < 3; k++) begin
      l = (m_rr + k) % 3;
      if (mask[l]) begin
        if (!(m_val[l] && m_tag[l] == a[l])) begin
          fa = full(l, a[l]);
          exp_req.push_back(fa);
          m_tag[l] = a[l];
          m_val[l] = 1'b1;
          m_dat[l] = mem(fa);
          last = l;
        end
        if (l == 0) exp_c.push_back(m_dat[0]);
        else if (l == 1) exp_s.push_back(m_dat[1]);
        else exp_o.push_back(m_dat[2]);
      end
    end
    if (last >= 0) m_rr = (last + 1) % 3;
  endtask

  task automatic wait_oks(input logic [2:0] mask);
    logic [2:0] seen;
    int n;
    seen = 3'b000;
    n = 0;
    while ((seen & mask) != mask && n < 3000) begin
      @(negedge clk);
      seen |= {obj_ok, scr_ok, char_ok};
      n++;
    end
    chk("ok_wait", 32'(seen & mask), 32'(mask));
  endtask

  task automatic drive(input logic [2:0] mask, input logic [17:0] a0,
                       input logic [17:0] a1, input logic [17:0] a2);
    char_addr = a0[14:0];
    scr_addr  = a1[16:0];
    obj_addr  = a2;
    char_cs   = mask[0];
    scr_cs    = mask[1];
    obj_cs    = mask[2];
  endtask

  task automatic do_txn(input logic [2:0] mask, input logic [17:0] a0,
                        input logic [17:0] a1, input logic [17:0] a2);
    model_fetch(mask, a0, a1, a2);
    tick();
    drive(mask, a0, a1, a2);
    wait_oks(mask);
    tick();
    char_cs = 1'b0;
    scr_cs  = 1'b0;
    obj_cs  = 1'b0;
  endtask

  function automatic logic [17:0] pool_addr();
    int r;
    r = int'($urandom_range(0, 4));
    return (r == 4) ? 18'h3FFFF : 18'(r * 'h1357);
  endfunction

  // SDRAM controller model
  initial begin : responder
    int ad, rd;
    forever begin
      @(posedge clk);
      #1;
      if (sdram_req && !mute && rst_n) begin
        ad = rand_mode ? int'($urandom_range(0, 3)) : ack_cfg;
        rd = rand_mode ? int'($urandom_range(0, 3)) : rdy_cfg;
        repeat (ad) begin @(posedge clk); #1; end
        sdram_ack = 1'b1;
        if (rd == 0) begin
          sdram_rdy  = 1'b1;
          sdram_data = force_en ? force_val : mem(sdram_addr);
        end
        @(posedge clk);
        #1;
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        if (rd > 0) begin
          repeat (rd - 1) begin @(posedge clk); #1; end
          sdram_rdy  = 1'b1;
          sdram_data = force_en ? force_val : mem(sdram_addr);
          @(posedge clk);
          #1;
          sdram_rdy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every new request and every rising ok.
  initial begin : monitor
    logic pr, pc, ps, po;
    logic [21:0] ea;
    logic [15:0] ed;
    pr = 1'b0; pc = 1'b0; ps = 1'b0; po = 1'b0;
    forever begin
      @(negedge clk);
      if (sdram_req && !pr) begin
        if (exp_req.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req: sdram_addr=%0h, no request required", sdram_addr);
        end else begin
          ea = exp_req.pop_front();
          chk("req_addr", 32'(sdram_addr), 32'(ea));
        end
      end
      if (char_ok && !pc) begin
        if (exp_c.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_char_ok: data=%0h, no ok required", char_data);
        end else begin
          ed = exp_c.pop_front();
          chk("char_data", 32'(char_data), 32'(ed));
        end
      end
      if (scr_ok && !ps) begin
        if (exp_s.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_scr_ok: data=%0h, no ok required", scr_data);
        end else begin
          ed = exp_s.pop_front();
          chk("scr_data", 32'(scr_data), 32'(ed));
        end
      end
      if (obj_ok && !po) begin
        if (exp_o.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_obj_ok: data=%0h, no ok required", obj_data);
        end else begin
          ed = exp_o.pop_front();
          chk("obj_data", 32'(obj_data), 32'(ed));
        end
      end
      pr = sdram_req; pc = char_ok; ps = scr_ok; po = obj_ok;
    end
  end

  initial begin : guard
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin : main
    int n, cnt;
    logic [17:0] a0, a1, a2;
    for (int i = 0; i < 3; i++) begin
      m_tag[i] = '0; m_val[i] = 1'b0; m_dat[i] = '0;
    end

    // reset state, with every layer requesting
    rst_n = 1'b0;
    drive(3'b111, 18'd0, 18'd0, 18'd0);
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(sdram_req), 0);
    chk("rst_addr", 32'(sdram_addr), 0);
    chk("rst_tcnt", 32'(timeout_cnt), 0);
    chk("rst_char_ok", 32'(char_ok), 0);
    chk("rst_scr_ok", 32'(scr_ok), 0);
    chk("rst_obj_ok", 32'(obj_ok), 0);
    chk("rst_char_data", 32'(char_data), 0);
    chk("rst_obj_data", 32'(obj_data), 0);
    drive(3'b000, 18'd0, 18'd0, 18'd0);
    tick();
    rst_n = 1'b1;

    // all three miss together, then scroll+object
    do_txn(3'b111, 18'h0101, 18'h0202, 18'h0303);
    do_txn(3'b110, 18'h0000, 18'h0404, 18'h0505);

    // scroll fetch of 0x1234 returning 0xBEEF
    ack_cfg = 2; rdy_cfg = 1; force_en = 1'b1; force_val = 16'hBEEF;
    exp_req.push_back(22'h11234);
    exp_s.push_back(16'hBEEF);
    m_tag[1] = 18'h1234; m_val[1] = 1'b1; m_dat[1] = 16'hBEEF; m_rr = 2;
    tick();
    drive(3'b010, 18'd0, 18'h1234, 18'h0505);
    @(negedge clk);
    chk("miss_req_lat0", 32'(sdram_req), 0);
    @(negedge clk);
    chk("miss_req_lat1", 32'(sdram_req), 1);
    wait_oks(3'b010);
    chk("beef_sdram_addr", 32'(sdram_addr), 32'h11234);
    tick();
    scr_cs = 1'b0;
    force_en = 1'b0;

    // repeat the same scroll address: answered from cache
    do_txn(3'b010, 18'd0, 18'h1234, 18'd0);

    // object address changes between ack and rdy
    ack_cfg = 1; rdy_cfg = 4;
    exp_req.push_back(full(2, 18'h2ABCD));
    exp_req.push_back(full(2, 18'h2ABCE));
    exp_o.push_back(mem(full(2, 18'h2ABCE)));
    m_tag[2] = 18'h2ABCE; m_val[2] = 1'b1; m_dat[2] = mem(full(2, 18'h2ABCE)); m_rr = 0;
    tick();
    drive(3'b100, 18'd0, 18'd0, 18'h2ABCD);
    n = 0;
    do begin @(negedge clk); n++; end while (!sdram_ack && n < 50);
    chk("chg_ack_seen", 32'(sdram_ack), 1);
    tick();
    obj_addr = 18'h2ABCE;
    n = 0;
    do begin @(negedge clk); n++; end while (!sdram_rdy && n < 50);
    chk("chg_rdy_seen", 32'(sdram_rdy), 1);
    @(negedge clk);
    chk("chg_obj_ok_low", 32'(obj_ok), 0);
    wait_oks(3'b100);
    tick();
    obj_cs = 1'b0;

    // randomized traffic
    rand_mode = 1'b1;
    for (int t = 0; t < 60; t++) begin
      a0 = pool_addr(); a1 = pool_addr(); a2 = pool_addr();
      do_txn(3'(int'($urandom_range(1, 7))), a0, a1, a2);
    end
    rand_mode = 1'b0;

    // downloading pulse after three hits
    ack_cfg = 1; rdy_cfg = 1;
    do_txn(3'b111, 18'h0440, 18'h0550, 18'h0660);
    model_fetch(3'b111, 18'h0440, 18'h0550, 18'h0660);
    tick();
    drive(3'b111, 18'h0440, 18'h0550, 18'h0660);
    wait_oks(3'b111);
    tick();
    downloading = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("dl_oks_low", 32'({obj_ok, scr_ok, char_ok}), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("dl_no_req", 32'(sdram_req), 0);
    end
    for (int i = 0; i < 3; i++) m_val[i] = 1'b0;
    model_fetch(3'b111, 18'h0440, 18'h0550, 18'h0660);
    tick();
    downloading = 1'b0;
    wait_oks(3'b111);
    tick();
    drive(3'b000, 18'h0440, 18'h0550, 18'h0660);

    // watchdog: controller never acks the char fetch; object waits behind it
    mute = 1'b1;
    exp_req.push_back(full(0, 18'h7ABC));
    exp_req.push_back(full(2, 18'h1F00F));
    exp_req.push_back(full(0, 18'h7ABC));
    exp_c.push_back(mem(full(0, 18'h7ABC)));
    exp_o.push_back(mem(full(2, 18'h1F00F)));
    m_tag[0] = 18'h7ABC; m_val[0] = 1'b1; m_dat[0] = mem(full(0, 18'h7ABC));
    m_tag[2] = 18'h1F00F; m_val[2] = 1'b1; m_dat[2] = mem(full(2, 18'h1F00F));
    m_rr = 1;
    tick();
    drive(3'b001, 18'h7ABC, 18'd0, 18'h1F00F);
    n = 0;
    do begin @(negedge clk); n++; end while (!sdram_req && n < 20);
    cnt = 1;
    tick();
    obj_cs = 1'b1;
    @(negedge clk);
    while (sdram_req && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    chk("wd_req_cycles", 32'(cnt), 255);
    chk("wd_tcnt", 32'(timeout_cnt), 1);
    chk("wd_char_ok", 32'(char_ok), 0);
    mute = 1'b0;
    wait_oks(3'b101);
    tick();
    drive(3'b000, 18'h7ABC, 18'd0, 18'h1F00F);

    // asynchronous reset in the middle of a fetch
    mute = 1'b1;
    exp_req.push_back(full(0, 18'h0ABC));
    tick();
    drive(3'b001, 18'h0ABC, 18'd0, 18'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!sdram_req && n < 20);
    chk("mid_req_up", 32'(sdram_req), 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(sdram_req), 0);
    drive(3'b000, 18'd0, 18'd0, 18'd0);
    repeat (3) @(negedge clk);
    chk("async_rst_tcnt", 32'(timeout_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      m_tag[i] = '0; m_val[i] = 1'b0; m_dat[i] = '0;
    end
    m_rr = 0;
    tick();
    rst_n = 1'b1;
    mute = 1'b0;
    do_txn(3'b111, 18'h0011, 18'h0022, 18'h0033);

    repeat (5) tick();
    chk("left_req", 32'(exp_req.size()), 0);
    chk("left_char", 32'(exp_c.size()), 0);
    chk("left_scr", 32'(exp_s.size()), 0);
    chk("left_obj", 32'(exp_o.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
